// File: rtl/exec_pkg.sv
// Shared EX-stage constants and types for the execute pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package exec_pkg;

    localparam int EX_WIDTH = 32;
    localparam int BR_SHAMT = 2;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/exec_shift_left_core.sv
// Branch-offset shift datapath: res = shift_in << SHAMT, plus optional signed-overflow flag.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the registered wrapper handles stall/flush. Optional flag: EXEC_SHIFT_LEFT_OVF_EN.
module exec_shift_left_core
    import exec_pkg::*;
#(
    parameter int WIDTH = EX_WIDTH,
    parameter int SHAMT = BR_SHAMT
) (
    input  logic [WIDTH-1:0] shift_in,
    output logic [WIDTH-1:0] res
`ifdef EXEC_SHIFT_LEFT_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Logical left shift: top SHAMT bits fall off, zeros enter the LSBs.
    assign res = shift_in << SHAMT;

`ifdef EXEC_SHIFT_LEFT_OVF_EN
    // The signed value survives the shift only if the bits that fall off
    // plus the new sign bit all match the original sign.
    logic [SHAMT:0] top_bits;
    assign top_bits = shift_in[WIDTH-1 -: SHAMT+1];
    assign ovf      = !((&top_bits) || !(|top_bits));
`endif

endmodule

// File: rtl/exec_shift_left.sv
// Registered branch-offset shifter for EX: shift_out = shift_in << SHAMT. Optional shift_ovf via EXEC_SHIFT_LEFT_OVF_EN.
// Latency: 1 cycle; result for inputs sampled at edge N is visible after edge N.
// Backpressure: stall holds all outputs, flush (higher priority) clears them; no ready output.
module exec_shift_left
    import exec_pkg::*;
#(
    parameter int WIDTH = EX_WIDTH,
    parameter int SHAMT = BR_SHAMT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] shift_in,
    output logic [WIDTH-1:0] shift_out,
    output logic             out_valid
`ifdef EXEC_SHIFT_LEFT_OVF_EN
    ,
    output logic             shift_ovf
`endif
);

    logic [WIDTH-1:0] res;

`ifdef EXEC_SHIFT_LEFT_OVF_EN
    logic ovf;

    exec_shift_left_core #(
        .WIDTH (WIDTH),
        .SHAMT (SHAMT)
    ) u_core (
        .shift_in (shift_in),
        .res      (res),
        .ovf      (ovf)
    );
`else
    exec_shift_left_core #(
        .WIDTH (WIDTH),
        .SHAMT (SHAMT)
    ) u_core (
        .shift_in (shift_in),
        .res      (res)
    );
`endif

    // Output register: flush beats stall beats load; data loads even when in_valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_out <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            shift_out <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            shift_out <= res;
            out_valid <= in_valid;
        end
    end

`ifdef EXEC_SHIFT_LEFT_OVF_EN
    // Overflow flag follows the same flush/stall/load priority as the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_ovf <= 1'b0;
        end else if (flush) begin
            shift_ovf <= 1'b0;
        end else if (!stall) begin
            shift_ovf <= ovf;
        end
    end
`endif

endmodule

// File: tb/tb_exec_shift_left.sv
// Self-checking bench for exec_shift_left: directed cases then randomized traffic vs. an arithmetic model.
// Latency: checks one cycle after each driven edge, sampled 1 time unit past the edge.
// Backpressure: exercises stall, flush and asynchronous reset; EXEC_SHIFT_LEFT_OVF_EN adds shift_ovf checks.
module tb_exec_shift_left;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [31:0] shift_in;
    logic [31:0] shift_out;
    logic        out_valid;
`ifdef EXEC_SHIFT_LEFT_OVF_EN
    logic        shift_ovf;
`endif

    int tests_run;
    int tests_failed;

    // Reference model state: what the outputs should hold.
    logic [31:0] m_out;
    logic        m_vld;
    logic        m_ovf;

    exec_shift_left dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .stall     (stall),
        .flush     (flush),
        .shift_in  (shift_in),
        .shift_out (shift_out),
        .out_valid (out_valid)
`ifdef EXEC_SHIFT_LEFT_OVF_EN
        ,
        .shift_ovf (shift_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Model: times four modulo 2^32; overflow when the signed product leaves int32 range.
    task automatic model_edge();
        longint prod;
        if (!rst_n) begin
            m_out = '0; m_vld = 1'b0; m_ovf = 1'b0;
        end else if (flush) begin
            m_out = '0; m_vld = 1'b0; m_ovf = 1'b0;
        end else if (!stall) begin
            prod  = longint'($signed(shift_in)) * 4;
            m_out = shift_in * 32'd4;
            m_vld = in_valid;
            m_ovf = (prod > 64'sd2147483647) || (prod < -64'sd2147483648);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_out"}, shift_out, m_out);
        check({tag, "_vld"}, {31'd0, out_valid}, {31'd0, m_vld});
`ifdef EXEC_SHIFT_LEFT_OVF_EN
        check({tag, "_ovf"}, {31'd0, shift_ovf}, {31'd0, m_ovf});
`endif
    endtask

    // Drive one cycle of inputs, clock it, update the model, then compare.
    task automatic cycle(input logic v, input logic s, input logic f, input logic [31:0] d, input string tag);
        in_valid = v; stall = s; flush = f; shift_in = d;
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    logic [31:0] specials [8];

    initial begin
        tests_run = 0; tests_failed = 0;
        m_out = '0; m_vld = 1'b0; m_ovf = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; shift_in = '0;

        // 1. Reset state, then a load of zero.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", shift_out, 32'h0);
        check("rst_vld", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, "t1");
        check("t1_vld_lit", {31'd0, out_valid}, 32'd1);

        // 2. Back-to-back loads.
        cycle(1'b1, 1'b0, 1'b0, 32'd1, "t2a");
        check("t2a_lit", shift_out, 32'd4);
        cycle(1'b1, 1'b0, 1'b0, 32'd8, "t2b");
        check("t2b_lit", shift_out, 32'd32);
        cycle(1'b1, 1'b0, 1'b0, 32'd100, "t2c");
        check("t2c_lit", shift_out, 32'd400);

        // 3. Sign and overflow.
        cycle(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, "t3a");
        check("t3a_lit", shift_out, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 1'b0, 32'hC000_0001, "t3b");
        check("t3b_lit", shift_out, 32'h0000_0004);
`ifdef EXEC_SHIFT_LEFT_OVF_EN
        check("t3b_ovf_lit", {31'd0, shift_ovf}, 32'd1);
`endif

        // 4. Stall holds the previous result.
        cycle(1'b1, 1'b0, 1'b0, 32'd8, "t4_load");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'd100, "t4_stall");
            check("t4_hold_lit", shift_out, 32'd32);
        end
        cycle(1'b1, 1'b0, 1'b0, 32'd100, "t4_rel");
        check("t4_rel_lit", shift_out, 32'd400);

        // 5. Flush wins over stall and drops the input.
        cycle(1'b1, 1'b1, 1'b1, 32'd5, "t5");
        check("t5_vld_lit", {31'd0, out_valid}, 32'd0);
        check("t5_out_lit", shift_out, 32'd0);

        // 6. Asynchronous reset between edges.
        cycle(1'b1, 1'b0, 1'b0, 32'd7, "t6_load");
        #2 rst_n = 1'b0;
        #1;
        m_out = '0; m_vld = 1'b0; m_ovf = 1'b0;
        check_model("t6_async");
        #1 rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 32'd3, "t6_post");

        // Randomized traffic.
        specials[0] = 32'hFFFF_FFFF; specials[1] = 32'hC000_0001;
        specials[2] = 32'h4000_0000; specials[3] = 32'h8000_0000;
        specials[4] = 32'h2000_0000; specials[5] = 32'hE000_0000;
        specials[6] = 32'h1FFF_FFFF; specials[7] = 32'hDFFF_FFFF;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] d;
            if ($urandom_range(0, 3) == 0) d = specials[$urandom_range(0, 7)];
            else                           d = $urandom;
            cycle(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 7) == 0),
                  d, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
